// File: rtl/binarization_thresh_ctrl.sv
// Per-frame adaptive binarization threshold: mean luma of the previous frame plus offset, clamped.
// Optional build macro THR_IIR_EN blends each new result into the previous threshold (3:1 IIR).
module binarization_thresh_ctrl #(
  parameter logic [7:0] DEFAULT_THR = 8'd64,
  parameter int         CNT_W       = 21,
  parameter int         THR_OFFSET  = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pre_frame_vsync,
  input  logic       pre_frame_de,
  input  logic [7:0] color,
  input  logic       thr_manual_en,
  input  logic [7:0] thr_manual,
  output logic [7:0] threshold,
  output logic       thr_valid,
  output logic       busy,
  output logic       frame_err
);

  localparam int SUM_W = CNT_W + 8;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic signed [9:0] OFFSET_S = 10'(THR_OFFSET);

  typedef enum logic [1:0] {
    ST_ACCUM,
    ST_DIVIDE,
    ST_UPDATE
  } state_t;

  state_t           state_q;
  logic             vsync_q;
  logic [SUM_W-1:0] sum_q;
  logic [CNT_W-1:0] count_q;
  logic [SUM_W-1:0] rem_q;
  logic [CNT_W-1:0] cnt_l_q;
  logic [7:0]       quo_q;
  logic [2:0]       idx_q;
  logic [7:0]       comp_q;
  logic [7:0]       thr_q;
  logic             valid_q;
  logic             busy_q;
  logic             err_q;

  logic             rise;
  logic [SUM_W-1:0] div_den;
  logic             div_ge;
  logic signed [9:0] t_s;
  logic [7:0]       t_clamp;
  logic [7:0]       comp_d;

  assign rise    = pre_frame_vsync & ~vsync_q;
  assign div_den = {8'b0, cnt_l_q} << idx_q;
  assign div_ge  = (rem_q >= div_den);

  // Quotient is at most 255 and the offset is 9-bit signed, so 10 bits never overflow.
  assign t_s     = $signed({2'b00, quo_q}) + OFFSET_S;
  assign t_clamp = t_s[9] ? 8'd0 : (t_s[8] ? 8'd255 : t_s[7:0]);

`ifdef THR_IIR_EN
  logic [9:0] iir_sum;
  assign iir_sum = {2'b00, comp_q} + {1'b0, comp_q, 1'b0} + {2'b00, t_clamp};
`endif

  always_comb begin
    comp_d = comp_q;
    if (state_q == ST_UPDATE && cnt_l_q != '0) begin
`ifdef THR_IIR_EN
      comp_d = iir_sum[9:2];
`else
      comp_d = t_clamp;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_ACCUM;
      vsync_q <= 1'b0;
      sum_q   <= '0;
      count_q <= '0;
      rem_q   <= '0;
      cnt_l_q <= '0;
      quo_q   <= '0;
      idx_q   <= '0;
      comp_q  <= DEFAULT_THR;
      thr_q   <= DEFAULT_THR;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      vsync_q <= pre_frame_vsync;
      comp_q  <= comp_d;
      thr_q   <= thr_manual_en ? thr_manual : comp_d;

      // Accumulation runs independently of the divider so the next frame is never lost.
      if (rise) begin
        sum_q   <= pre_frame_de ? {{CNT_W{1'b0}}, color} : '0;
        count_q <= pre_frame_de ? CNT_ONE : '0;
      end else if (pre_frame_de) begin
        if (count_q == '1) begin
          err_q <= 1'b1;
        end else begin
          sum_q   <= sum_q + {{CNT_W{1'b0}}, color};
          count_q <= count_q + CNT_ONE;
        end
      end

      case (state_q)
        ST_ACCUM: begin
          if (rise) begin
            rem_q   <= sum_q;
            cnt_l_q <= count_q;
            quo_q   <= '0;
            idx_q   <= 3'd7;
            busy_q  <= 1'b1;
            state_q <= ST_DIVIDE;
          end
        end
        ST_DIVIDE: begin
          if (rise) err_q <= 1'b1;
          if (div_ge) begin
            rem_q        <= rem_q - div_den;
            quo_q[idx_q] <= 1'b1;
          end
          if (idx_q == 3'd0) begin
            valid_q <= (cnt_l_q != '0);
            state_q <= ST_UPDATE;
          end else begin
            idx_q <= idx_q - 3'd1;
          end
        end
        ST_UPDATE: begin
          if (rise) err_q <= 1'b1;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_ACCUM;
        end
        default: state_q <= ST_ACCUM;
      endcase
    end
  end

  assign threshold = thr_q;
  assign thr_valid = valid_q;
  assign busy      = busy_q;
  assign frame_err = err_q;

endmodule

// File: tb/tb_binarization_thresh_ctrl.sv
// Randomized and directed bench for binarization_thresh_ctrl; three instances differ only in offset.
module tb_binarization_thresh_ctrl;

  localparam int OFFS [3] = '{0, -200, 200};
  localparam int CMAX = (1 << 21) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       vs = 1'b0;
  logic       de = 1'b0;
  logic [7:0] col = 8'd0;
  logic       m_en = 1'b0;
  logic [7:0] m_val = 8'd0;

  logic [7:0] thr_w  [3];
  logic       vld_w  [3];
  logic       busy_w [3];
  logic       err_w  [3];

  binarization_thresh_ctrl #(.DEFAULT_THR(8'd64), .CNT_W(21), .THR_OFFSET(0)) u_dut0 (
    .clk(clk), .rst(rst), .pre_frame_vsync(vs), .pre_frame_de(de), .color(col),
    .thr_manual_en(m_en), .thr_manual(m_val), .threshold(thr_w[0]), .thr_valid(vld_w[0]),
    .busy(busy_w[0]), .frame_err(err_w[0]));
  binarization_thresh_ctrl #(.DEFAULT_THR(8'd64), .CNT_W(21), .THR_OFFSET(-200)) u_dut1 (
    .clk(clk), .rst(rst), .pre_frame_vsync(vs), .pre_frame_de(de), .color(col),
    .thr_manual_en(m_en), .thr_manual(m_val), .threshold(thr_w[1]), .thr_valid(vld_w[1]),
    .busy(busy_w[1]), .frame_err(err_w[1]));
  binarization_thresh_ctrl #(.DEFAULT_THR(8'd64), .CNT_W(21), .THR_OFFSET(200)) u_dut2 (
    .clk(clk), .rst(rst), .pre_frame_vsync(vs), .pre_frame_de(de), .color(col),
    .thr_manual_en(m_en), .thr_manual(m_val), .threshold(thr_w[2]), .thr_valid(vld_w[2]),
    .busy(busy_w[2]), .frame_err(err_w[2]));

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int vld_seen = 0;

  // Reference: frame totals plus the cycle stamp of the accepted boundary.
  longint m_sum;
  int     m_cnt;
  bit     m_prev_vs;
  bit     m_err;
  bit     m_act;
  int     m_n;
  longint p_sum;
  int     p_cnt;
  int     m_comp [3];
  int     m_thr  [3];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  function automatic int next_thr(input int mean, input int off, input int old);
    int t;
    t = mean + off;
    if (t < 0) t = 0;
    if (t > 255) t = 255;
`ifdef THR_IIR_EN
    return (3 * old + t) / 4;
`else
    return t;
`endif
  endfunction

  task automatic model_edge();
    bit busy_now;
    bit rise;
    if (rst) begin
      m_sum = 0; m_cnt = 0; m_prev_vs = 0; m_err = 0; m_act = 0;
      for (int i = 0; i < 3; i++) begin
        m_comp[i] = 64;
        m_thr[i]  = 64;
      end
    end else begin
      busy_now = m_act && cyc >= m_n + 1 && cyc <= m_n + 9;
      if (m_act && cyc == m_n + 9) begin
        if (p_cnt != 0)
          for (int i = 0; i < 3; i++)
            m_comp[i] = next_thr(int'(p_sum / p_cnt), OFFS[i], m_comp[i]);
        m_act = 0;
      end
      rise = vs && !m_prev_vs;
      m_prev_vs = vs;
      if (rise) begin
        if (busy_now) m_err = 1;
        else begin
          p_sum = m_sum; p_cnt = m_cnt; m_n = cyc; m_act = 1;
        end
        m_sum = de ? col : 0;
        m_cnt = de ? 1 : 0;
      end else if (de) begin
        if (m_cnt == CMAX) m_err = 1;
        else begin
          m_sum += col;
          m_cnt++;
        end
      end
      for (int i = 0; i < 3; i++) m_thr[i] = m_en ? int'(m_val) : m_comp[i];
    end
  endtask

  task automatic step(input logic r, input logic v, input logic d, input logic [7:0] c);
    bit e_busy;
    bit e_vld;
    rst = r; vs = v; de = d; col = c;
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    e_busy = m_act && cyc >= m_n && cyc <= m_n + 8;
    e_vld  = m_act && cyc == m_n + 8 && p_cnt != 0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("thr%0d", i), thr_w[i], m_thr[i]);
      chk($sformatf("valid%0d", i), vld_w[i], e_vld);
      chk($sformatf("busy%0d", i), busy_w[i], e_busy);
      chk($sformatf("err%0d", i), err_w[i], m_err);
    end
    if (vld_w[0]) vld_seen++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 8'd0);
  endtask

  task automatic pixels(input int n, input int c);
    logic [7:0] v;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0) step(1'b0, 1'b0, 1'b0, 8'd0);
      v = (c < 0) ? 8'($urandom_range(0, 255)) : 8'(c);
      step(1'b0, 1'b0, 1'b1, v);
    end
  endtask

  task automatic vs_pulse(input int hold, input logic d0, input logic [7:0] c0);
    step(1'b0, 1'b1, d0, c0);
    for (int i = 1; i < hold; i++) step(1'b0, 1'b1, 1'b0, 8'd0);
  endtask

  initial begin
    step(1'b1, 1'b0, 1'b0, 8'd0);
    step(1'b1, 1'b0, 1'b0, 8'd0);
    idle(5);
    chk("rst_thr", thr_w[0], 64);
    chk("rst_valid", vld_w[0], 0);
    chk("rst_busy", busy_w[0], 0);
    chk("rst_err", err_w[0], 0);

    pixels(16, 100);
    vs_pulse(1, 1'b0, 8'd0);
    idle(12);
`ifndef THR_IIR_EN
    chk("mean100", thr_w[0], 100);
`endif

    pixels(0, 0);
    step(1'b0, 1'b0, 1'b1, 8'd0);
    step(1'b0, 1'b0, 1'b1, 8'd0);
    step(1'b0, 1'b0, 1'b1, 8'd255);
    step(1'b0, 1'b0, 1'b1, 8'd255);
    vs_pulse(2, 1'b0, 8'd0);
    idle(12);
    chk("clamp_lo", thr_w[1], 0);
    chk("clamp_hi", thr_w[2], 255);
`ifndef THR_IIR_EN
    chk("mean127", thr_w[0], 127);
`endif

    vld_seen = 0;
    vs_pulse(1, 1'b0, 8'd0);
    idle(12);
    chk("empty_novalid", vld_seen, 0);
`ifndef THR_IIR_EN
    chk("empty_hold", thr_w[0], 127);
`endif

    m_val = 8'd30;
    m_en = 1'b1;
    idle(1);
    chk("man_thr", thr_w[0], 30);
    vld_seen = 0;
    pixels(16, 100);
    vs_pulse(1, 1'b0, 8'd0);
    idle(12);
    chk("man_hold", thr_w[0], 30);
    chk("man_valid", vld_seen, 1);
    m_en = 1'b0;
    idle(1);
`ifndef THR_IIR_EN
    chk("man_release", thr_w[0], 100);
`endif

    vld_seen = 0;
    pixels(8, 50);
    vs_pulse(1, 1'b0, 8'd0);
    idle(3);
    step(1'b1, 1'b0, 1'b0, 8'd0);
    idle(12);
    chk("abort_novalid", vld_seen, 0);
    chk("abort_thr", thr_w[0], 64);
    chk("abort_busy", busy_w[0], 0);

    pixels(4, 128);
    vs_pulse(1, 1'b0, 8'd0);
    idle(12);
`ifdef THR_IIR_EN
    chk("iir_80", thr_w[0], 80);
`else
    chk("mean128", thr_w[0], 128);
`endif

    for (int f = 0; f < 10; f++) begin
      m_en  = ($urandom_range(0, 3) == 0);
      m_val = 8'($urandom_range(0, 255));
      pixels($urandom_range(0, 40), -1);
      vs_pulse($urandom_range(1, 3), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
      idle($urandom_range(10, 14));
    end
    m_en = 1'b0;
    idle(1);

    pixels(8, 200);
    vs_pulse(1, 1'b0, 8'd0);
    idle(3);
    vs_pulse(1, 1'b0, 8'd0);
    idle(12);
    chk("busy_rise_err", err_w[0], 1);

    for (int f = 0; f < 8; f++) begin
      m_en  = ($urandom_range(0, 3) == 0);
      m_val = 8'($urandom_range(0, 255));
      pixels($urandom_range(0, 40), -1);
      vs_pulse($urandom_range(1, 3), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
      idle($urandom_range(4, 14));
    end
    idle(12);
    chk("err_sticky", err_w[0], 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
